// File: rtl/serial_gp_adder_pkg.sv
// Shared definitions for the bit-serial G/P adder: controller state encoding.
package serial_gp_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_gp_adder_gp_cell.sv
// Single-bit generate/propagate cell: g/p terms plus the sum bit for an incoming carry.
module gp_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic g,
  output logic p,
  output logic s
);

  assign g = x & y;
  assign p = x ^ y;
  assign s = p ^ c;

endmodule

// File: rtl/serial_gp_adder.sv
// Bit-serial adder/subtractor: one gp_cell plus a carry register, LSB first,
// with a start/busy/done handshake.
module serial_gp_adder
  import serial_gp_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned IW = $clog2(WIDTH) + 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x_sr, y_sr, sum_r;
  logic [IW-1:0]    idx;
  logic             carry, c_msb, cout_r, ovf_r;
  logic             g, p, s, c_nx;
  logic             last_bit, msb_in_bit;

  assign last_bit   = (idx == IW'(WIDTH - 1));
  assign msb_in_bit = (idx == IW'(WIDTH - 2));

  // Operands shift right so the active bit is always at position 0.
  gp_cell u_cell (
    .x (x_sr[0]),
    .y (y_sr[0]),
    .c (carry),
    .g (g),
    .p (p),
    .s (s)
  );

  assign c_nx = g | (p & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)    state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sr   <= '0;
      y_sr   <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_sr  <= a;
            y_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          x_sr  <= x_sr >> 1;
          y_sr  <= y_sr >> 1;
          // Sum bits enter at the MSB and settle into place after WIDTH shifts.
          sum_r <= {s, sum_r[WIDTH-1:1]};
          carry <= c_nx;
          idx   <= idx + IW'(1);
          if (msb_in_bit) c_msb <= c_nx;
          if (last_bit) begin
            cout_r <= c_nx;
            ovf_r  <= c_msb ^ c_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: doc/serial_gp_adder.md
Name: serial_gp_adder

Overview:
Bit-serial adder/subtractor that consumes generate/propagate terms one bit per clock. It is the sequential carry-resolving end of the G/P interface: a per-bit cell produces g/p/s, and this block closes the loop with a carry register, c_next = g | (p & c). It sits beside the parallel lookahead adders as a low-area alternative with a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored), sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
cin  input  1  carry-in for add, sampled with start
busy  output  1  high in RUN
done  output  1  one-cycle pulse when result becomes valid
sum  output  WIDTH  result; held stable from done until next accepted start
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  two's-complement overflow = carry into MSB XOR cout

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). Asserting rst_n low forces state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit index=0, carry=0, operand shift registers=0. This applies at any time, including mid-RUN; a partial result is discarded and not reported.
- States: IDLE, RUN, DONE.
- IDLE: on a clock edge with start=1, latch x=a, y=(sub ? ~b : b), carry=(sub ? 1 : cin), index=0, and go to RUN. start=0 keeps the block in IDLE.
- RUN: each edge processes bit index:
  - g = x[i] & y[i]; p = x[i] ^ y[i]
  - sum[i] = p ^ carry
  - carry = g | (p & carry); index++
- Operands are LSB-first. Shift registers or an index mux are both acceptable; only the external behaviour is specified.
- On the edge that processes i = WIDTH-2, capture the carry-out (the carry into the MSB) for ovf.
- On the edge that processes i = WIDTH-1, write cout and ovf, then go to DONE.
- busy=1 for exactly WIDTH cycles.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing.
- Latency: start is sampled at edge k; done is high during the cycle after edge k+WIDTH. Back-to-back throughput is one op per WIDTH+2 cycles.
- sum bits update progressively during RUN. sum is defined valid only from done onward.
- Modulo 2^WIDTH arithmetic; no saturation.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module, gp_cell: combinational (x, y, c) -> (g, p, s). Instantiate it once, fed by the selected bit and the carry register.
- The index counter width is $clog2(WIDTH)+1.

Test Plan:
- WIDTH=8, add a=0x5A, b=0x3C, cin=0 -> done 9 cycles after the start edge; sum=0x96, cout=0, ovf=1; busy high for 8 cycles.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
- Sub a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. Sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start pulsed every cycle during RUN with different operands -> only the first op is executed; exactly one done pulse; then the next start in IDLE is accepted.
- rst_n low at RUN cycle 4, released 2 cycles later -> all outputs 0; no done pulse; a new add of 0x01+0x01 gives sum=0x02.
- Back-to-back ops with start held high -> accepted at IDLE edges only; done pulses spaced WIDTH+2 cycles apart; sum stable between done and the next accepted start.
